fruit_grid_renderer: RTL and testbench

//   Pipelined pixel renderer for the POS product grid: GRID_COLS x GRID_ROWS tiles, each one sprite from a shared

---
 rtl/fruit_grid_renderer_if.sv | 16 +
 rtl/fruit_grid_renderer.sv | 135 +++++++++++++
 tb/tb_fruit_grid_renderer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fruit_grid_renderer_if.sv
// Pixel-side bus of the product-grid renderer: sync-counter coordinates in,
// sprite ROM port, and the colour word out to the DAC.
interface fruit_grid_renderer_if #(
  parameter int AW = 15
);
  logic [9:0]    x;
  logic [9:0]    y;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;

  modport master (output x, y, rom_data, input rom_addr, red, green, blue);
  modport slave  (input x, y, rom_data, output rom_addr, red, green, blue);
endinterface

// File: rtl/fruit_grid_renderer.sv
// Two-stage pixel renderer for the POS product grid, with a button-driven
// cursor frame and a product-select pulse.
module fruit_grid_renderer #(
  parameter int          TILE_W    = 50,
  parameter int          TILE_H    = 50,
  parameter int          GRID_COLS = 4,
  parameter int          GRID_ROWS = 3,
  parameter int          ORIGIN_X  = 15,
  parameter int          ORIGIN_Y  = 230,
  parameter int          PITCH_X   = 80,
  parameter int          PITCH_Y   = 80,
  parameter int          N_SPRITES = 12,
  parameter int          BORDER    = 2,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [23:0] BG_RGB    = 24'h2D7887,
  parameter logic [23:0] HL_RGB    = 24'hFFFF00,
  parameter logic [23:0] KEY_RGB   = 24'hFF00FF,
  localparam int         AW        = $clog2(N_SPRITES * TILE_W * TILE_H),
  localparam int         CW        = $clog2(GRID_COLS * GRID_ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  fruit_grid_renderer_if.slave   bus,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_sel,
  output logic [CW-1:0]          cursor_idx,
  output logic                   sel_valid,
  output logic [CW-1:0]          sel_code
);

  localparam int COLW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int ROWW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam logic [COLW-1:0] COL_MAX = COLW'(GRID_COLS - 1);
  localparam logic [ROWW-1:0] ROW_MAX = ROWW'(GRID_ROWS - 1);

  // ---------------- cursor and select ----------------
  logic [COLW-1:0] col_q;
  logic [ROWW-1:0] row_q;
  logic            sel_ok;

  always_comb begin
    cursor_idx = CW'(int'(row_q) * GRID_COLS + int'(col_q));
    sel_ok     = btn_sel && (int'(cursor_idx) < N_SPRITES);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      sel_valid <= 1'b0;
      sel_code  <= '0;
    end else begin
      // Opposing pulses on one axis cancel; the two axes are independent.
      if (btn_right && !btn_left)      col_q <= (col_q == COL_MAX) ? '0 : col_q + 1'b1;
      else if (btn_left && !btn_right) col_q <= (col_q == '0) ? COL_MAX : col_q - 1'b1;
      if (btn_down && !btn_up)         row_q <= (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      else if (btn_up && !btn_down)    row_q <= (row_q == '0) ? ROW_MAX : row_q - 1'b1;
      // Select reports the cursor as it stood before any same-cycle move.
      sel_valid <= sel_ok;
      if (sel_ok) sel_code <= cursor_idx;
    end
  end

  // ---------------- S1: tile decode by constant compare chain ----------------
  int            xi, yi, dx, dy, col, row, ox, oy, idx;
  logic          in_grid, in_tile, on_border, visible;
  logic [AW-1:0] addr_next;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    xi  = int'({22'd0, bus.x});
    yi  = int'({22'd0, bus.y});
    dx  = xi - ORIGIN_X;
    dy  = yi - ORIGIN_Y;
    col = 0;
    row = 0;
    for (int k = 1; k <= GRID_COLS; k++) if (dx >= k * PITCH_X) col = k;
    for (int k = 1; k <= GRID_ROWS; k++) if (dy >= k * PITCH_Y) row = k;
    ox  = dx - col * PITCH_X;
    oy  = dy - row * PITCH_Y;
    idx = row * GRID_COLS + col;

    in_grid   = (dx >= 0) && (dy >= 0) && (col < GRID_COLS) && (row < GRID_ROWS) &&
                (ox < TILE_W) && (oy < TILE_H);
    in_tile   = in_grid && (idx < N_SPRITES);
    on_border = in_grid && ((ox < BORDER) || (ox >= TILE_W - BORDER) ||
                            (oy < BORDER) || (oy >= TILE_H - BORDER));
    visible   = (xi < H_ACTIVE) && (yi < V_ACTIVE);
    addr_next = in_tile ? AW'(idx * TILE_W * TILE_H + oy * TILE_W + ox) : '0;
  end

  logic          in_tile_q, border_q, vis_q;
  logic [CW-1:0] tile_q, cur_s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rom_addr <= '0;
      in_tile_q    <= 1'b0;
      border_q     <= 1'b0;
      vis_q        <= 1'b0;
      tile_q       <= '0;
      cur_s1_q     <= '0;
    end else begin
      bus.rom_addr <= addr_next;
      in_tile_q    <= in_tile;
      border_q     <= on_border;
      vis_q        <= visible;
      tile_q       <= CW'(idx);
      // Cursor travels with the pixel so a move never tears a frame mid-pixel.
      cur_s1_q     <= cursor_idx;
    end
  end

  // ---------------- S2: colour select ----------------
  logic [23:0] rgb_q;

  always_ff @(posedge clk) begin
    if (rst)                                           rgb_q <= '0;
    else if (!vis_q)                                   rgb_q <= '0;
    else if (border_q && (tile_q == cur_s1_q))         rgb_q <= HL_RGB;
    else if (in_tile_q && (bus.rom_data != KEY_RGB))   rgb_q <= bus.rom_data;
    else                                               rgb_q <= BG_RGB;
  end

  assign bus.red   = rgb_q[23:16];
  assign bus.green = rgb_q[15:8];
  assign bus.blue  = rgb_q[7:0];

endmodule

// File: tb/tb_fruit_grid_renderer.sv
// Directed bench for fruit_grid_renderer: pixel pipeline, cursor moves,
// select pulse and mid-line reset, against hand-computed values.
module tb_fruit_grid_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left, btn_right, btn_up, btn_down, btn_sel;
  logic [3:0] cursor_idx;
  logic       sel_valid;
  logic [3:0] sel_code;
  logic       key_force;

  int checks = 0;
  int errors = 0;

  fruit_grid_renderer_if #(.AW(15)) bus ();

  fruit_grid_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_sel    (btn_sel),
    .cursor_idx (cursor_idx),
    .sel_valid  (sel_valid),
    .sel_code   (sel_code)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: word = 0x100000 ^ address, or the colour key on demand.
  assign bus.rom_data = key_force ? 24'hFF00FF : (24'h100000 ^ {9'd0, bus.rom_addr});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'd0, bus.red, bus.green, bus.blue};
  endfunction

  // Buttons as {left, right, up, down, sel}; outputs checked by caller at edge+1.
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {btn_left, btn_right, btn_up, btn_down, btn_sel} = b;
    @(posedge clk);
    #1;
    {btn_left, btn_right, btn_up, btn_down, btn_sel} = 5'b0;
  endtask

  task automatic pixel(input string tag, input int px, input int py,
                       input logic [31:0] exp_addr, input logic [31:0] exp_rgb);
    @(negedge clk);
    bus.x = 10'(px);
    bus.y = 10'(py);
    @(posedge clk);
    #1 check({tag, "_addr"}, 32'(bus.rom_addr), exp_addr);
    @(posedge clk);
    #1 check({tag, "_rgb"}, rgb(), exp_rgb);
  endtask

  initial begin
    rst = 1'b1;
    key_force = 1'b0;
    bus.x = '0;
    bus.y = '0;
    {btn_left, btn_right, btn_up, btn_down, btn_sel} = 5'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb",      rgb(), 32'h0);
    check("rst_addr",     32'(bus.rom_addr), 32'd0);
    check("rst_cursor",   32'(cursor_idx), 32'd0);
    check("rst_selvalid", 32'(sel_valid), 32'd0);
    check("rst_selcode",  32'(sel_code), 32'd0);
    rst = 1'b0;

    // Cursor moves with wrap, cancel and combined axes.
    press(5'b10000); check("left_wrap",   32'(cursor_idx), 32'd3);
    press(5'b00100); check("up_wrap",     32'(cursor_idx), 32'd11);
    press(5'b11000); check("lr_cancel",   32'(cursor_idx), 32'd11);
    press(5'b10010); check("down_left",   32'(cursor_idx), 32'd2);
    press(5'b00010); check("down_to_6",   32'(cursor_idx), 32'd6);

    // Pixel pipeline with cursor on tile 6.
    pixel("tile0_origin", 15,  230, 32'd0,     32'h100000);
    pixel("tile0_last",   64,  279, 32'd2499,  32'h1009C3);
    pixel("tile5_origin", 95,  310, 32'd12500, 32'h1030D4);
    pixel("gap",          70,  240, 32'd0,     32'h2D7887);
    pixel("x_offscreen",  640, 240, 32'd0,     32'h0);
    pixel("y_offscreen",  95,  480, 32'd0,     32'h0);
    pixel("cur_frame_tl", 175, 310, 32'd15000, 32'hFFFF00);
    pixel("cur_frame_br", 224, 359, 32'd17499, 32'hFFFF00);
    pixel("cur_inner",    177, 312, 32'd15102, 32'h103AFE);
    key_force = 1'b1;
    pixel("key_bg",       177, 312, 32'd15102, 32'h2D7887);
    key_force = 1'b0;

    // Select wins over a same-cycle move; pulse lasts one clock.
    press(5'b01001);
    check("sel_valid",  32'(sel_valid), 32'd1);
    check("sel_code",   32'(sel_code), 32'd6);
    check("sel_moved",  32'(cursor_idx), 32'd7);
    @(posedge clk);
    #1 check("sel_pulse_end", 32'(sel_valid), 32'd0);
    check("sel_code_held", 32'(sel_code), 32'd6);

    // Walk to tile 9, select, then reset mid-line.
    press(5'b00010);
    press(5'b01000);
    press(5'b01000); check("cursor_9", 32'(cursor_idx), 32'd9);
    press(5'b00001); check("sel9_code", 32'(sel_code), 32'd9);
    pixel("pre_rst", 95, 310, 32'd12500, 32'h1030D4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_rgb", rgb(), 32'h0);
    check("mid_rst_cursor",   32'(cursor_idx), 32'd0);
    check("mid_rst_selvalid", 32'(sel_valid), 32'd0);
    check("mid_rst_selcode",  32'(sel_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst1_addr", 32'(bus.rom_addr), 32'd12500);
    check("post_rst1_rgb", rgb(), 32'h0);
    @(posedge clk);
    #1 check("post_rst2_rgb", rgb(), 32'h1030D4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
